// File: rtl/regfile_nport_if.sv
// Write/read bundle of the N-entry register file.
// master drives addresses and write data; slave returns the two read words.
interface regfile_nport_if #(
    parameter int WIDTH     = 32,
    parameter int ADDR_BITS = 5
);
    logic                 Wen;
    logic [ADDR_BITS-1:0] WAddr;
    logic [WIDTH-1:0]     WData;
    logic [ADDR_BITS-1:0] RAddrA;
    logic [WIDTH-1:0]     RDataA;
    logic [ADDR_BITS-1:0] RAddrB;
    logic [WIDTH-1:0]     RDataB;

    modport master (
        output Wen, WAddr, WData, RAddrA, RAddrB,
        input  RDataA, RDataB
    );

    modport slave (
        input  Wen, WAddr, WData, RAddrA, RAddrB,
        output RDataA, RDataB
    );
endinterface

// File: rtl/regfile_nport.sv
// Parametrised register file: one falling-edge write port, two async read ports.
// Optional hardwired-zero entry 0 and optional write-to-read bypass.
module regfile_nport #(
    parameter int               WIDTH       = 32,
    parameter int               ADDR_BITS   = 5,
    parameter bit               ZERO_REG    = 1'b1,
    parameter bit               BYPASS      = 1'b0,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input logic             C,
    input logic             CLR,
    regfile_nport_if.slave  bus
);

    localparam int DEPTH = 1 << ADDR_BITS;

    logic [WIDTH-1:0] mem [DEPTH];

    for (genvar i = 0; i < DEPTH; i++) begin : g_entry
        if (ZERO_REG && i == 0) begin : g_zero
            assign mem[i] = '0;
        end else begin : g_reg
            logic [WIDTH-1:0] q;
            logic             hit;

            assign hit = bus.Wen && (bus.WAddr == ADDR_BITS'(i));

            always_ff @(negedge C or posedge CLR) begin
                if (CLR) begin
                    q <= RESET_VALUE;
                end else if (hit) begin
                    q <= bus.WData;
                end
            end

            assign mem[i] = q;
        end
    end

    // Bypass is gated by CLR so reset contents are never masked
    logic wr_live;
    logic byp_a;
    logic byp_b;
    logic zero_a;
    logic zero_b;

    assign wr_live = bus.Wen && !CLR;
    assign byp_a   = BYPASS && wr_live && (bus.RAddrA == bus.WAddr);
    assign byp_b   = BYPASS && wr_live && (bus.RAddrB == bus.WAddr);
    assign zero_a  = ZERO_REG && (bus.RAddrA == '0);
    assign zero_b  = ZERO_REG && (bus.RAddrB == '0);

    logic [WIDTH-1:0] rdata_a;
    logic [WIDTH-1:0] rdata_b;

    always_comb begin
        rdata_a = mem[bus.RAddrA];
        if (byp_a) begin
            rdata_a = bus.WData;
        end
        if (zero_a) begin
            rdata_a = '0;
        end
    end

    always_comb begin
        rdata_b = mem[bus.RAddrB];
        if (byp_b) begin
            rdata_b = bus.WData;
        end
        if (zero_b) begin
            rdata_b = '0;
        end
    end

    assign bus.RDataA = rdata_a;
    assign bus.RDataB = rdata_b;

endmodule

// File: tb/tb_regfile_nport.sv
// Directed bench for regfile_nport: three instances cover zero-reg,
// bypass and a narrow 8-entry configuration.
module tb_regfile_nport;

    logic C;
    logic CLR;
    logic armed;
    int   checks;
    int   errors;

    regfile_nport_if #(.WIDTH(32), .ADDR_BITS(5)) bus0 ();
    regfile_nport_if #(.WIDTH(32), .ADDR_BITS(5)) bus1 ();
    regfile_nport_if #(.WIDTH(8),  .ADDR_BITS(3)) bus2 ();

    // u1 sees exactly the same stimulus as u0
    assign bus1.Wen    = bus0.Wen;
    assign bus1.WAddr  = bus0.WAddr;
    assign bus1.WData  = bus0.WData;
    assign bus1.RAddrA = bus0.RAddrA;
    assign bus1.RAddrB = bus0.RAddrB;

    regfile_nport #(
        .WIDTH(32), .ADDR_BITS(5), .ZERO_REG(1'b1), .BYPASS(1'b0),
        .RESET_VALUE(32'hDEADBEEF)
    ) u0 (.C(C), .CLR(CLR), .bus(bus0));

    regfile_nport #(
        .WIDTH(32), .ADDR_BITS(5), .ZERO_REG(1'b0), .BYPASS(1'b1),
        .RESET_VALUE(32'hDEADBEEF)
    ) u1 (.C(C), .CLR(CLR), .bus(bus1));

    regfile_nport #(
        .WIDTH(8), .ADDR_BITS(3), .ZERO_REG(1'b1), .BYPASS(1'b0),
        .RESET_VALUE(8'h5A)
    ) u2 (.C(C), .CLR(CLR), .bus(bus2));

    initial begin
        C = 1'b1;
        forever #5 C = ~C;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: sim time %0t exceeded limit", $time);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge C);
        #1;
    endtask

    task automatic commit();
        @(negedge C);
        #1;
    endtask

    always @(negedge C) begin
        if (armed) begin
            #2;
            checks++;
            if ($isunknown({bus0.RDataA, bus0.RDataB, bus1.RDataA,
                            bus1.RDataB, bus2.RDataA, bus2.RDataB})) begin
                errors++;
                $display("FAIL xcheck: unknown read data at %0t", $time);
            end
        end
    end

    typedef struct {
        logic        wen;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic [4:0]  ra;
        logic [4:0]  rb;
        logic [31:0] ea0;
        logic [31:0] eb0;
        logic [31:0] ea1;
        logic [31:0] eb1;
    } vec_t;

    vec_t vecs[6];

    initial begin
        vecs[0] = '{1'b1, 5'd7,  32'h12345678, 5'd7,  5'd7,
                    32'h12345678, 32'h12345678, 32'h12345678, 32'h12345678};
        vecs[1] = '{1'b0, 5'd7,  32'hFFFFFFFF, 5'd7,  5'd0,
                    32'h12345678, 32'h0,        32'h12345678, 32'hDEADBEEF};
        vecs[2] = '{1'b1, 5'd0,  32'hAAAA5555, 5'd0,  5'd5,
                    32'h0,        32'hDEADBEEF, 32'hAAAA5555, 32'hDEADBEEF};
        vecs[3] = '{1'b1, 5'd3,  32'h11111111, 5'd3,  5'd7,
                    32'h11111111, 32'h12345678, 32'h11111111, 32'h12345678};
        vecs[4] = '{1'b0, 5'd3,  32'h00000000, 5'd0,  5'd3,
                    32'h0,        32'h11111111, 32'hAAAA5555, 32'h11111111};
        vecs[5] = '{1'b1, 5'd31, 32'hCAFEF00D, 5'd31, 5'd1,
                    32'hCAFEF00D, 32'hDEADBEEF, 32'hCAFEF00D, 32'hDEADBEEF};

        checks = 0;
        errors = 0;
        armed  = 1'b0;
        CLR    = 1'b0;
        bus0.Wen = 1'b0;  bus0.WAddr = '0;  bus0.WData = '0;
        bus0.RAddrA = 5'd5;  bus0.RAddrB = 5'd0;
        bus2.Wen = 1'b0;  bus2.WAddr = '0;  bus2.WData = '0;
        bus2.RAddrA = 3'd5;  bus2.RAddrB = 3'd0;

        // reset asserted mid high phase, no clock edge in between
        #2 CLR = 1'b1;
        #1;
        check("rst_u0_a5", bus0.RDataA, 32'hDEADBEEF);
        check("rst_u0_b0", bus0.RDataB, 32'h0);
        check("rst_u1_b0", bus1.RDataB, 32'hDEADBEEF);
        check("rst_u2_a5", {24'h0, bus2.RDataA}, 32'h5A);
        check("rst_u2_b0", {24'h0, bus2.RDataB}, 32'h0);
        step();
        CLR = 1'b0;
        armed = 1'b1;

        for (int i = 0; i < 6; i++) begin
            step();
            bus0.Wen    = vecs[i].wen;
            bus0.WAddr  = vecs[i].waddr;
            bus0.WData  = vecs[i].wdata;
            bus0.RAddrA = vecs[i].ra;
            bus0.RAddrB = vecs[i].rb;
            commit();
            check($sformatf("vec%0d_u0_a", i), bus0.RDataA, vecs[i].ea0);
            check($sformatf("vec%0d_u0_b", i), bus0.RDataB, vecs[i].eb0);
            check($sformatf("vec%0d_u1_a", i), bus1.RDataA, vecs[i].ea1);
            check($sformatf("vec%0d_u1_b", i), bus1.RDataB, vecs[i].eb1);
        end

        // same-address write/read: bypass versus stored value
        step();
        bus0.Wen = 1'b1;  bus0.WAddr = 5'd3;  bus0.WData = 32'h22222222;
        bus0.RAddrA = 5'd3;  bus0.RAddrB = 5'd3;
        #1;
        check("byp_pre_u0_a", bus0.RDataA, 32'h11111111);
        check("byp_pre_u0_b", bus0.RDataB, 32'h11111111);
        check("byp_pre_u1_a", bus1.RDataA, 32'h22222222);
        check("byp_pre_u1_b", bus1.RDataB, 32'h22222222);
        commit();
        check("byp_post_u0_a", bus0.RDataA, 32'h22222222);
        check("byp_post_u0_b", bus0.RDataB, 32'h22222222);
        step();
        bus0.Wen = 1'b0;
        #1;
        check("byp_held_u1_a", bus1.RDataA, 32'h22222222);

        for (int a = 1; a < 32; a++) begin
            step();
            bus0.Wen = 1'b1;
            bus0.WAddr = 5'(a);
            bus0.WData = 32'(a);
            commit();
        end
        step();
        bus0.Wen = 1'b0;
        for (int a = 0; a < 32; a++) begin
            bus0.RAddrA = 5'(a);
            bus0.RAddrB = 5'(31 - a);
            #1;
            check($sformatf("fill_u0_a%0d", a), bus0.RDataA,
                  (a == 0) ? 32'h0 : 32'(a));
            check($sformatf("fill_u1_b%0d", 31 - a), bus1.RDataB,
                  (a == 31) ? 32'hAAAA5555 : 32'(31 - a));
        end

        // reset in the middle of a live write spanning a falling edge
        step();
        bus0.Wen = 1'b1;  bus0.WAddr = 5'd9;  bus0.WData = 32'h99;
        bus0.RAddrA = 5'd9;  bus0.RAddrB = 5'd9;
        #1;
        check("midrst_byp_live", bus1.RDataA, 32'h99);
        CLR = 1'b1;
        #1;
        check("midrst_u0_a9", bus0.RDataA, 32'hDEADBEEF);
        check("midrst_u1_nobyp", bus1.RDataA, 32'hDEADBEEF);
        commit();
        check("midrst_edge_u0", bus0.RDataA, 32'hDEADBEEF);
        check("midrst_edge_u1", bus1.RDataB, 32'hDEADBEEF);
        step();
        bus0.Wen = 1'b0;
        #1 CLR = 1'b0;
        for (int a = 0; a < 32; a++) begin
            bus0.RAddrA = 5'(a);
            bus0.RAddrB = 5'(a);
            #1;
            check($sformatf("postrst_u0_%0d", a), bus0.RDataA,
                  (a == 0) ? 32'h0 : 32'hDEADBEEF);
            check($sformatf("postrst_u1_%0d", a), bus1.RDataB, 32'hDEADBEEF);
        end

        // first falling edge after reset release commits
        step();
        bus0.Wen = 1'b1;  bus0.WAddr = 5'd9;  bus0.WData = 32'h55;
        bus0.RAddrA = 5'd9;
        commit();
        check("first_wr_u0", bus0.RDataA, 32'h55);
        step();
        bus0.Wen = 1'b0;
        #1;
        check("first_wr_u1", bus1.RDataA, 32'h55);

        // narrow configuration sweep
        for (int i = 0; i < 8; i++) begin
            step();
            bus2.Wen = 1'b1;
            bus2.WAddr = 3'(i);
            bus2.WData = 8'hA0 + 8'(i);
            commit();
        end
        step();
        bus2.Wen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            bus2.RAddrA = 3'(i);
            bus2.RAddrB = 3'(7 - i);
            #1;
            check($sformatf("sweep_a%0d", i), {24'h0, bus2.RDataA},
                  (i == 0) ? 32'h0 : 32'hA0 + 32'(i));
            check($sformatf("sweep_b%0d", 7 - i), {24'h0, bus2.RDataB},
                  (i == 7) ? 32'h0 : 32'hA0 + 32'(7 - i));
        end

        step();
        armed = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
